// File: rtl/key_debounce_pulse_pkg.sv
// rtl/key_debounce_pulse_pkg.sv - shared state encoding and defaults for the key debouncer
package key_debounce_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    // 20 ms window at a 50 MHz clock
    localparam int unsigned DEFAULT_STABLE_CYCLES = 1000000;
    localparam int unsigned DEFAULT_CNT_W         = 20;

    // Raw pin value of a released key for the given polarity
    function automatic logic released_value(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/key_debounce_pulse_if.sv
// rtl/key_debounce_pulse_if.sv - raw key input and debounced level/strobe outputs
interface key_debounce_pulse_if;

    logic Key_in;
    logic Level;
    logic Press_pulse;
    logic Release_pulse;

    modport master (
        output Key_in,
        input  Level,
        input  Press_pulse,
        input  Release_pulse
    );

    modport slave (
        input  Key_in,
        output Level,
        output Press_pulse,
        output Release_pulse
    );

endinterface

// File: rtl/key_debounce_pulse_sync_2ff.sv
// rtl/key_debounce_pulse_sync_2ff.sv - 1-bit two-flop synchroniser with parameterised reset value
module key_debounce_pulse_sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic Clock,
    input  logic Reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce_pulse.sv
// rtl/key_debounce_pulse.sv - pushbutton debouncer producing a level and one-cycle press/release strobes
module key_debounce_pulse
    import key_debounce_pulse_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int unsigned CNT_W         = DEFAULT_CNT_W,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    key_debounce_pulse_if.slave  key
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic      key_sync;
    logic      sk;
    db_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic      level_q, level_d;
    logic      press_q, press_d;
    logic      release_q, release_d;

    key_debounce_pulse_sync_2ff #(
        .RESET_VAL (released_value(ACTIVE_LOW))
    ) u_sync (
        .Clock (Clock),
        .Reset (Reset),
        .d     (key.Key_in),
        .q     (key_sync)
    );

    // sk is 1 whenever the key is physically pressed, whatever the pin polarity
    assign sk = key_sync ^ ACTIVE_LOW;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= CNT_ZERO;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sk) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!sk) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = CNT_ZERO;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!sk) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                // A pressed sample here is bounce: fall back without a strobe
                if (sk) begin
                    state_d = HELD;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = CNT_ZERO;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
                level_d = 1'b0;
            end
        endcase
    end

    assign key.Level         = level_q;
    assign key.Press_pulse   = press_q;
    assign key.Release_pulse = release_q;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// tb/tb_key_debounce_pulse.sv - scoreboard bench for key_debounce_pulse against a sample-window model
module tb_key_debounce_pulse;

    localparam int SA = 4;
    localparam int SB = 3;

    typedef struct packed {
        logic lvl;
        logic pr;
        logic rl;
    } exp_t;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    bit   pressed = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    key_debounce_pulse_if ifa ();
    key_debounce_pulse_if ifb ();

    assign ifa.Key_in = ~pressed;
    assign ifb.Key_in = pressed;

    key_debounce_pulse #(.STABLE_CYCLES(SA), .CNT_W(8), .ACTIVE_LOW(1'b1)) dut_a (
        .Clock (Clock),
        .Reset (Reset),
        .key   (ifa.slave)
    );

    key_debounce_pulse #(.STABLE_CYCLES(SB), .CNT_W(8), .ACTIVE_LOW(1'b0)) dut_b (
        .Clock (Clock),
        .Reset (Reset),
        .key   (ifb.slave)
    );

    always #5 Clock = ~Clock;

    // Reference: the key is seen two edges late; the level flips once the last S samples all oppose it
    bit          m_p1 [2];
    bit          m_p2 [2];
    bit          m_lvl [2];
    logic [15:0] m_hist [2];
    int          m_n [2];
    exp_t        q_a [$];
    exp_t        q_b [$];

    task automatic model_step(input int i, input bit pn, input bit rst, input int s, output exp_t e);
        bit sk;
        logic [15:0] mask;
        e = '0;
        if (rst) begin
            m_p1[i] = 0; m_p2[i] = 0; m_lvl[i] = 0; m_hist[i] = '0; m_n[i] = 0;
        end else begin
            sk        = m_p2[i];
            m_p2[i]   = m_p1[i];
            m_p1[i]   = pn;
            m_hist[i] = {m_hist[i][14:0], sk};
            m_n[i]    = m_n[i] + 1;
            mask      = (16'(1) << s) - 16'(1);
            if (m_n[i] >= s && (m_hist[i] & mask) == (m_lvl[i] ? 16'h0 : mask)) begin
                m_lvl[i] = !m_lvl[i];
                if (m_lvl[i]) e.pr = 1'b1;
                else          e.rl = 1'b1;
                m_n[i] = 0;
            end
        end
        e.lvl = m_lvl[i];
    endtask

    always @(posedge Clock) begin : model_proc
        exp_t e;
        model_step(0, pressed, Reset, SA, e);
        q_a.push_back(e);
        model_step(1, pressed, Reset, SB, e);
        q_b.push_back(e);
    end

    task automatic check(input string nm, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%b exp=%b t=%0t", nm, got, exp, $time);
    endtask

    always @(negedge Clock) begin : monitor_proc
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check("dut_a lvl/press/rel", {2'b0, ifa.Level, ifa.Press_pulse, ifa.Release_pulse}, {2'b0, e});
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check("dut_b lvl/press/rel", {2'b0, ifb.Level, ifb.Press_pulse, ifb.Release_pulse}, {2'b0, e});
        end
    end

    // Downstream modulo counter advanced by the press strobe, wrapping after 20
    logic [4:0] cnt20 = '0;
    bit         cnt_clr = 1'b0;
    always @(posedge Clock) begin
        if (cnt_clr)               cnt20 <= '0;
        else if (ifa.Press_pulse)  cnt20 <= (cnt20 == 5'd20) ? 5'd0 : cnt20 + 5'd1;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    initial begin
        logic [4:0] c0;
        int r;
        cyc(3);
        Reset = 1'b0;
        cyc(4);

        pressed = 1'b1; cyc(30);
        pressed = 1'b0; cyc(30);

        for (int i = 0; i < 10; i++) begin
            pressed = ~pressed; cyc(2);
        end
        pressed = 1'b0; cyc(20);

        pressed = 1'b1; cyc(4);
        Reset = 1'b1;   cyc(1);
        Reset = 1'b0;   cyc(20);
        pressed = 1'b0; cyc(20);

        repeat (150) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                Reset = 1'b1; cyc(1); Reset = 1'b0;
            end else if (r < 5) begin
                pressed = ~pressed;
                cyc($urandom_range(1, 10));
            end else begin
                repeat ($urandom_range(2, 12)) begin
                    pressed = 1'($urandom_range(0, 1));
                    cyc(1);
                end
            end
        end
        pressed = 1'b0; cyc(20);

        cnt_clr = 1'b1; cyc(1); cnt_clr = 1'b0;
        for (int i = 1; i <= 21; i++) begin
            pressed = 1'b1; cyc(8);
            pressed = 1'b0; cyc(8);
            check("counter after press", cnt20, 5'(i % 21));
        end
        c0 = cnt20;
        pressed = 1'b1; cyc(100);
        pressed = 1'b0; cyc(10);
        check("counter long hold", cnt20, (c0 == 5'd20) ? 5'd0 : c0 + 5'd1);

        cyc(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
